// File: rtl/fixed_div_three_if.sv
// Start/busy/done handshake bundle for the fixed_div_three divider.
// The controller side uses the master modport and the divider uses the slave modport.
interface fixed_div_three_if #(
   parameter int DIV_WIDTH    = 17,
   parameter int RESULT_WIDTH = 32
);
   logic                    start;
   logic [DIV_WIDTH-1:0]    div_a;
   logic [DIV_WIDTH-1:0]    div_b;
   logic                    busy;
   logic                    done;
   logic                    div_zero;
   logic [RESULT_WIDTH-1:0] data_q;

   modport master (
      output start, div_a, div_b,
      input  busy, done, div_zero, data_q
   );

   modport slave (
      input  start, div_a, div_b,
      output busy, done, div_zero, data_q
   );
endinterface

// File: rtl/fixed_div_three.sv
// Iterative signed Q16 divider that computes div_a / div_b.
// Operands are converted to magnitudes, and a restoring shift-subtract engine then
// produces one quotient bit per clock. A final step applies the sign, saturates the
// result, and handles a zero divisor. Latency is always 34 clocks from accept to done.
module fixed_div_three #(
   parameter int DIV_WIDTH    = 17,
   parameter int FRAC_BITS    = 16,
   parameter int RESULT_WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   fixed_div_three_if.slave  bus
);

   localparam int QW = DIV_WIDTH + FRAC_BITS;   // numerator / quotient magnitude width
   localparam int CW = $clog2(QW + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [RESULT_WIDTH-1:0] RES_POS_MAX = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
   localparam logic [RESULT_WIDTH-1:0] RES_NEG_MAX = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
   localparam logic [RESULT_WIDTH-1:0] RES_ZERO    = {RESULT_WIDTH{1'b0}};
   localparam logic [RESULT_WIDTH-1:0] RES_ONE     = {{(RESULT_WIDTH-1){1'b0}}, 1'b1};

   // The largest quotient magnitudes that fit in the positive and negative output ranges.
   localparam logic [QW-1:0] Q_POS_MAX = {{(QW-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
   localparam logic [QW-1:0] Q_NEG_MAX = {{(QW-RESULT_WIDTH){1'b0}}, 1'b1, {(RESULT_WIDTH-1){1'b0}}};
   localparam logic [QW-1:0] Q_ZERO    = {QW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Absolute value of a two's-complement operand. The most negative value maps to 2^(N-1).
   function automatic logic [DIV_WIDTH-1:0] mag_of(input logic [DIV_WIDTH-1:0] v);
      logic [DIV_WIDTH-1:0] m;
      if (v[DIV_WIDTH-1]) begin
         m = ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Signs and saturates a quotient magnitude. A zero magnitude never becomes negative zero.
   function automatic logic [RESULT_WIDTH-1:0] fix_result(input logic [QW-1:0] q,
                                                          input logic       neg);
      logic [RESULT_WIDTH-1:0] r;
      if (q == Q_ZERO) begin
         r = RES_ZERO;
      end else if (!neg) begin
         if (q > Q_POS_MAX) begin
            r = RES_POS_MAX;
         end else begin
            r = q[RESULT_WIDTH-1:0];
         end
      end else begin
         if (q > Q_NEG_MAX) begin
            r = RES_NEG_MAX;
         end else begin
            r = ~q[RESULT_WIDTH-1:0] + RES_ONE;
         end
      end
      return r;
   endfunction

   state_t                  state_r, state_s;
   logic [QW-1:0]           num_r;
   logic [QW-1:0]           quot_r;
   logic [DIV_WIDTH-1:0]    rem_r;
   logic [DIV_WIDTH-1:0]    mag_b_r;
   logic [CW-1:0]           cnt_r;
   logic                    sign_r;
   logic                    sign_a_r;
   logic                    zflag_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    div_zero_r;
   logic [RESULT_WIDTH-1:0] data_q_r;

   logic [DIV_WIDTH:0]      rem_ext_s;
   logic                    rem_ge_s;
   logic [DIV_WIDTH-1:0]    rem_next_s;
   logic [RESULT_WIDTH-1:0] result_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic. Start is only looked at in IDLE, so a request while busy is dropped.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_ITER;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ITER: begin
            if (cnt_r == CNT_LAST) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_ITER;
            end
         end
         ST_FIX:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // One restoring step: bring down the next numerator bit, then subtract the divisor if it fits.
   // When the subtraction is taken the difference is below mag_b, so the low bits are sufficient.
   always_comb begin
      rem_ext_s = {rem_r, num_r[QW-1]};
      rem_ge_s  = (rem_ext_s >= {1'b0, mag_b_r});
      if (rem_ge_s) begin
         rem_next_s = rem_ext_s[DIV_WIDTH-1:0] - mag_b_r;
      end else begin
         rem_next_s = rem_ext_s[DIV_WIDTH-1:0];
      end
   end

   // Final result selection. A zero divisor saturates toward the sign of the dividend alone.
   always_comb begin
      result_s = RES_ZERO;
      if (zflag_r) begin
         if (sign_a_r) begin
            result_s = RES_NEG_MAX;
         end else begin
            result_s = RES_POS_MAX;
         end
      end else begin
         result_s = fix_result(quot_r, sign_r);
      end
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_r      <= {QW{1'b0}};
         quot_r     <= {QW{1'b0}};
         rem_r      <= {DIV_WIDTH{1'b0}};
         mag_b_r    <= {DIV_WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         sign_r     <= 1'b0;
         sign_a_r   <= 1'b0;
         zflag_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         data_q_r   <= RES_ZERO;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  num_r    <= {mag_of(bus.div_a), {FRAC_BITS{1'b0}}};
                  quot_r   <= {QW{1'b0}};
                  rem_r    <= {DIV_WIDTH{1'b0}};
                  mag_b_r  <= mag_of(bus.div_b);
                  cnt_r    <= {CW{1'b0}};
                  sign_r   <= bus.div_a[DIV_WIDTH-1] ^ bus.div_b[DIV_WIDTH-1];
                  sign_a_r <= bus.div_a[DIV_WIDTH-1];
                  zflag_r  <= (bus.div_b == {DIV_WIDTH{1'b0}});
                  busy_r   <= 1'b1;
               end else begin
                  busy_r   <= 1'b0;
               end
            end
            ST_ITER: begin
               num_r  <= {num_r[QW-2:0], 1'b0};
               rem_r  <= rem_next_s;
               quot_r <= {quot_r[QW-2:0], rem_ge_s};
               cnt_r  <= cnt_r + CNT_ONE;
            end
            ST_FIX: begin
               data_q_r   <= result_s;
               div_zero_r <= zflag_r;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
   assign bus.data_q   = data_q_r;

endmodule

// File: tb/tb_fixed_div_three.sv
// Self-checking bench for fixed_div_three: directed cases plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_fixed_div_three;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fixed_div_three_if #(.DIV_WIDTH(17), .RESULT_WIDTH(32)) bus ();

   fixed_div_three #(.DIV_WIDTH(17), .FRAC_BITS(16), .RESULT_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: real-valued a/b in Q16, truncated toward zero, then saturated.
   // Bit 32 of the return value is the div_zero flag.
   function automatic logic [32:0] ref_div(input logic [16:0] a, input logic [16:0] b);
      longint sa, sb, ma, mb, q;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         return (sa < 0) ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
      end
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      q  = (ma * 65536) / mb;
      if (q == 0) return {1'b0, 32'h0000_0000};
      if ((sa < 0) == (sb < 0)) begin
         if (q > 64'sd2147483647) return {1'b0, 32'h7FFF_FFFF};
         t = 64'(q);
      end else begin
         if (q > 64'sd2147483648) return {1'b0, 32'h8000_0000};
         t = 64'(-q);
      end
      return {1'b0, t[31:0]};
   endfunction

   // Issue one operation, then check latency, busy span, the result, and the result hold.
   task automatic run_op(input logic [16:0] a, input logic [16:0] b, input logic [31:0] exp_q,
                         input logic exp_z, input bit repulse, input string tag);
      int cyc = 0;
      int busy_cnt = 0;
      bit seen = 1'b0;
      bus.div_a = a;
      bus.div_b = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_val({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
      while (!seen && cyc < 45) begin
         if (repulse && cyc == 10) begin
            bus.start = 1'b1;
            bus.div_a = 17'h00001;
            bus.div_b = 17'h00003;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (bus.done) seen = 1'b1;
         else if (bus.busy) busy_cnt++;
      end
      bus.start = 1'b0;
      check_val({tag, "_latency"},  64'(cyc), 64'd34);
      check_val({tag, "_busy_span"}, 64'(busy_cnt), 64'd33);
      check_val({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
      check_val({tag, "_data_q"},   64'(bus.data_q), 64'(exp_q));
      check_val({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_z));
      @(posedge clk); #1;
      check_val({tag, "_done_fall"}, 64'(bus.done), 64'd0);
      check_val({tag, "_q_hold"},    64'(bus.data_q), 64'(exp_q));
      check_val({tag, "_z_hold"},    64'(bus.div_zero), 64'(exp_z));
   endtask

   initial begin
      logic [32:0] r;
      logic [16:0] ra, rb;
      int cyc, d1, d2, dones;
      logic [31:0] q1, q2;

      bus.start = 1'b0;
      bus.div_a = 17'h0;
      bus.div_b = 17'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy",   64'(bus.busy),     64'd0);
      check_val("rst_done",   64'(bus.done),     64'd0);
      check_val("rst_zero",   64'(bus.div_zero), 64'd0);
      check_val("rst_data_q", 64'(bus.data_q),   64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_op(17'h04000, 17'h08000, 32'h0000_8000, 1'b0, 1'b0, "t1_quarter_half");
      run_op(17'h18000, 17'h04000, 32'hFFFE_0000, 1'b0, 1'b0, "t2_neg_a");
      run_op(17'h08000, 17'h1C000, 32'hFFFE_0000, 1'b0, 1'b0, "t2_neg_b");
      run_op(17'h10000, 17'h00001, 32'h8000_0000, 1'b0, 1'b0, "t3_sat_neg");
      run_op(17'h0FFFF, 17'h00001, 32'h7FFF_FFFF, 1'b0, 1'b0, "t3_sat_pos");
      run_op(17'h04000, 17'h00000, 32'h7FFF_FFFF, 1'b1, 1'b0, "t4_dz_pos");
      run_op(17'h18000, 17'h00000, 32'h8000_0000, 1'b1, 1'b0, "t4_dz_neg");
      run_op(17'h04000, 17'h08000, 32'h0000_8000, 1'b0, 1'b0, "t4_dz_clear");
      run_op(17'h00000, 17'h00000, 32'h7FFF_FFFF, 1'b1, 1'b0, "t4_zero_zero");
      run_op(17'h18000, 17'h04000, 32'hFFFE_0000, 1'b0, 1'b1, "t5_repulse");
      run_op(17'h00000, 17'h18000, 32'h0000_0000, 1'b0, 1'b0, "t6_zero_dividend");

      // Start held high: back-to-back accepts at E0 and E35
      bus.div_a = 17'h04000;
      bus.div_b = 17'h08000;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.div_a = 17'h18000;
      bus.div_b = 17'h04000;
      cyc = 0; d1 = 0; d2 = 0; q1 = 32'h0; q2 = 32'h0;
      while (d2 == 0 && cyc < 90) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 35) bus.start = 1'b0;
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = cyc;
               q1 = bus.data_q;
            end else begin
               d2 = cyc;
               q2 = bus.data_q;
            end
         end
      end
      bus.start = 1'b0;
      check_val("t5_held_done1", 64'(d1), 64'd34);
      check_val("t5_held_q1",    64'(q1), 64'h0000_8000);
      check_val("t5_held_done2", 64'(d2), 64'd69);
      check_val("t5_held_q2",    64'(q2), 64'hFFFE_0000);
      @(posedge clk); #1;

      // Reset in the middle of an operation
      bus.div_a = 17'h04000;
      bus.div_b = 17'h08000;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_busy",   64'(bus.busy),   64'd0);
      check_val("t6_rst_done",   64'(bus.done),   64'd0);
      check_val("t6_rst_data_q", 64'(bus.data_q), 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check_val("t6_no_done", 64'(dones), 64'd0);
      check_val("t6_idle_busy", 64'(bus.busy), 64'd0);
      run_op(17'h18000, 17'h04000, 32'hFFFE_0000, 1'b0, 1'b0, "t6_after_rst");

      // Randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = 17'($urandom_range(0, 17'h1FFFF));
         case (i % 4)
            0:       rb = 17'($urandom_range(0, 17'h1FFFF));
            1:       rb = 17'($urandom_range(0, 17'h000FF));
            2:       rb = {1'b1, 16'($urandom_range(0, 16'h00FF))};
            default: rb = 17'($urandom_range(17'h04000, 17'h0FFFF));
         endcase
         r = ref_div(ra, rb);
         run_op(ra, rb, r[31:0], r[32], 1'b0, $sformatf("rnd%0d_%05h_%05h", i, ra, rb));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
